// File: rtl/modinv_arbiter_if.sv
// ============================================================================
// Module   : modinv_arbiter_if
// Purpose  : Requester, response and modular-inverse core channels of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface modinv_arbiter_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int NUM_REQ    = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_base;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_mod;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_res;
  logic                          inv_din_valid;
  logic                          inv_din_ready;
  logic [DATA_WIDTH-1:0]         inv_din_base;
  logic [DATA_WIDTH-1:0]         inv_din_mod;
  logic                          inv_dout_valid;
  logic                          inv_dout_ready;
  logic [DATA_WIDTH-1:0]         inv_dout_res;
  logic                          busy;
  logic [IW-1:0]                 owner;
  logic [15:0]                   last_latency;

  modport slave (
    input  req_valid, req_base, req_mod, rsp_ready,
    input  inv_din_ready, inv_dout_valid, inv_dout_res,
    output req_ready, rsp_valid, rsp_res,
    output inv_din_valid, inv_din_base, inv_din_mod, inv_dout_ready,
    output busy, owner, last_latency
  );

  modport master (
    output req_valid, req_base, req_mod, rsp_ready,
    output inv_din_ready, inv_dout_valid, inv_dout_res,
    input  req_ready, rsp_valid, rsp_res,
    input  inv_din_valid, inv_din_base, inv_din_mod, inv_dout_ready,
    input  busy, owner, last_latency
  );
endinterface

`default_nettype wire

// File: rtl/modinv_arbiter.sv
// ============================================================================
// Module   : modinv_arbiter
// Purpose  : Round-robin arbiter sharing one modular-inverse core among NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modinv_arbiter #(
  parameter int DATA_WIDTH = 1024,
  parameter int NUM_REQ    = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  modinv_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RES = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_grant_vld;
  logic [DATA_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_mod;
  logic [DATA_WIDTH-1:0] r_res;
  logic [15:0]           r_lat_cnt;
  logic [15:0]           r_last_lat;
  logic [15:0]           w_lat_inc;

  // Scan offsets high to low so the requester nearest after last_grant wins.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last_grant) + k) % NUM_REQ);
      if (bus.req_valid[w_idx]) begin
        w_grant     = w_idx;
        w_grant_vld = 1'b1;
      end
    end
  end

  assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? r_lat_cnt : r_lat_cnt + 16'd1;

  always_comb begin
    w_state_nxt        = r_state;
    bus.req_ready      = '0;
    bus.rsp_valid      = '0;
    bus.inv_din_valid  = 1'b0;
    bus.inv_dout_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            bus.req_ready[w_grant] = 1'b1;
            w_state_nxt            = S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.inv_din_valid = 1'b1;
          if (bus.inv_din_ready) w_state_nxt = S_WAIT_RES;
        end
        S_WAIT_RES: begin
          bus.inv_dout_ready = 1'b1;
          if (bus.inv_dout_valid) w_state_nxt = S_RETURN;
        end
        S_RETURN: begin
          bus.rsp_valid[r_owner] = 1'b1;
          if (bus.rsp_ready[r_owner]) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_base       <= '0;
      r_mod        <= '0;
      r_res        <= '0;
      r_lat_cnt    <= '0;
      r_last_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_base  <= bus.req_base[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
            r_mod   <= bus.req_mod[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
            r_owner <= w_grant;
          end
        end
        S_ISSUE: begin
          if (bus.inv_din_ready) r_lat_cnt <= '0;
        end
        S_WAIT_RES: begin
          r_lat_cnt <= w_lat_inc;
          if (bus.inv_dout_valid) begin
            r_res      <= bus.inv_dout_res;
            r_last_lat <= w_lat_inc;
          end
        end
        S_RETURN: begin
          if (bus.rsp_ready[r_owner]) r_last_grant <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = !rst && (r_state != S_IDLE);
  assign bus.owner        = r_owner;
  assign bus.last_latency = r_last_lat;
  assign bus.rsp_res      = r_res;
  assign bus.inv_din_base = r_base;
  assign bus.inv_din_mod  = r_mod;

endmodule

`default_nettype wire

// File: tb/tb_modinv_arbiter.sv
// ============================================================================
// Module   : tb_modinv_arbiter
// Purpose  : Scoreboard bench for modinv_arbiter with a brute-force inverse core stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modinv_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;

  typedef struct {
    int          owner;
    logic [15:0] res;
    logic [15:0] lat;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  int          core_din_stall;
  int          core_delay;
  logic        force_dv;
  logic [15:0] force_res;
  int          cst;
  int          ccnt;
  logic [15:0] lb;
  logic [15:0] lm;
  int          order [5];
  int          g;

  modinv_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  modinv_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] modinv(input logic [15:0] b, input logic [15:0] m);
    for (int x = 1; x < int'(m); x++)
      if ((int'(b) * x) % int'(m) == 1) return 16'(x);
    return 16'd0;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    chk("jobs_done_in_budget", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Core stub: ready after core_din_stall cycles, result core_delay WAIT cycles later.
  initial begin
    cst = 0; ccnt = 0; lb = '0; lm = '0;
    bus.inv_din_ready = 1'b0; bus.inv_dout_valid = 1'b0; bus.inv_dout_res = '0;
    forever begin
      @(negedge clk);
      bus.inv_din_ready  = 1'b0;
      bus.inv_dout_valid = 1'b0;
      if (rst) cst = 0;
      else begin
        if (cst == 3) cst = 0;
        if (cst == 0 && bus.inv_din_valid) begin ccnt = core_din_stall; cst = 1; end
        if (cst == 1) begin
          if (ccnt == 0) begin
            bus.inv_din_ready = 1'b1;
            lb = bus.inv_din_base; lm = bus.inv_din_mod;
            ccnt = core_delay; cst = 2;
          end else ccnt--;
        end else if (cst == 2) begin
          ccnt--;
          if (ccnt == 0) begin
            bus.inv_dout_valid = 1'b1;
            bus.inv_dout_res   = modinv(lb, lm);
            cst = 3;
          end
        end
      end
      if (force_dv) begin bus.inv_dout_valid = 1'b1; bus.inv_dout_res = force_res; end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (bus.rsp_valid != '0 && exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: rsp_valid=%b expected none", bus.rsp_valid);
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.rsp_valid[i] && bus.rsp_ready[i] && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_owner", i, e.owner);
            chk("rsp_res", bus.rsp_res, e.res);
            chk("last_latency", bus.last_latency, e.lat);
          end
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; force_dv = 1'b0; force_res = '0;
    core_din_stall = 0; core_delay = 1;
    order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0; bus.rsp_ready = '1;
    bus.req_base  = {16'd5, 16'd4, 16'd2, 16'd3};
    bus.req_mod   = {16'd11, 16'd9, 16'd5, 16'd7};

    // Reset: outputs quiet even with a pending request
    @(negedge clk); bus.req_valid = 4'b0001; #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_din_valid", bus.inv_din_valid, 0);
    chk("rst_dout_ready", bus.inv_dout_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);

    // Single job: 3^-1 mod 7 = 5, 10 core cycles
    @(negedge clk);
    core_delay = 10;
    exp_q.push_back('{0, 16'd5, 16'd10});
    rst = 1'b0; #2;
    chk("post_rst_owner", bus.owner, 0);
    chk("post_rst_last_latency", bus.last_latency, 0);
    chk("post_rst_rsp_res", bus.rsp_res, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("single_req_ready", bus.req_ready, 4'b0001);
    @(negedge clk); bus.req_valid = '0; #2;
    chk("single_din_valid_t1", bus.inv_din_valid, 1);
    chk("single_din_base", bus.inv_din_base, 3);
    chk("single_din_mod", bus.inv_din_mod, 7);
    wait_done(100);
    @(negedge clk); #2;
    chk("single_busy_fall", bus.busy, 0);
    chk("single_rsp_valid_low", bus.rsp_valid, 0);

    // Contention: all four held from reset, grant order 0,1,2,3,0
    @(negedge clk); rst = 1'b1; bus.req_valid = 4'b1111; core_delay = 1;
    exp_q.push_back('{0, 16'd5, 16'd1});
    exp_q.push_back('{1, 16'd3, 16'd1});
    exp_q.push_back('{2, 16'd7, 16'd1});
    exp_q.push_back('{3, 16'd9, 16'd1});
    exp_q.push_back('{0, 16'd5, 16'd1});
    @(negedge clk); rst = 1'b0;
    g = 0;
    for (int c = 0; c < 100 && g < 5; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      chk("req_ready_onehot", ($countones(bus.req_ready) <= 1), 1);
      if (bus.req_ready != '0) begin
        chk("grant_order", idx_of(bus.req_ready), order[g]);
        g++;
      end
    end
    chk("grants_in_budget", g, 5);
    @(negedge clk); bus.req_valid = '0;
    wait_done(100);

    // Backpressure: core input stalled 5 cycles, owner response stalled 3
    @(negedge clk);
    bus.rsp_ready = 4'b1101; core_din_stall = 5; core_delay = 3;
    bus.req_valid = 4'b0010;
    exp_q.push_back('{1, 16'd3, 16'd3});
    #2 chk("bp_req_ready", bus.req_ready, 4'b0010);
    @(negedge clk); bus.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      chk("bp_din_valid", bus.inv_din_valid, 1);
      chk("bp_din_base", bus.inv_din_base, 2);
      chk("bp_din_mod", bus.inv_din_mod, 5);
    end
    for (int c = 0; c < 50 && bus.rsp_valid == '0; c++) begin @(negedge clk); #2; end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #2; end
      chk("bp_rsp_valid_held", bus.rsp_valid, 4'b0010);
      chk("bp_rsp_res_held", bus.rsp_res, 3);
    end
    @(negedge clk); bus.rsp_ready = 4'b0010;
    wait_done(20);
    @(negedge clk); bus.rsp_ready = '1; core_din_stall = 0; #2;
    chk("rsp_res_hold_idle", bus.rsp_res, 3);

    // Withdraw: requester 2 pulses while requester 1 is served
    @(negedge clk); core_delay = 6; bus.req_valid = 4'b0010;
    exp_q.push_back('{1, 16'd3, 16'd6});
    #2 chk("wd_req_ready", bus.req_ready, 4'b0010);
    @(negedge clk); bus.req_valid = '0;
    for (int c = 0; c < 20 && !bus.inv_dout_ready; c++) begin @(negedge clk); #2; end
    @(negedge clk); bus.req_valid = 4'b0100; #2;
    chk("wd_no_ready_busy", bus.req_ready, 0);
    @(negedge clk); bus.req_valid = '0; #2;
    chk("wd_no_ready_after", bus.req_ready, 0);
    wait_done(50);
    @(negedge clk); #2;
    chk("wd_idle", bus.busy, 0);
    chk("wd_owner_kept", bus.owner, 1);
    repeat (2) @(negedge clk);
    #2 chk("wd_no_late_grant", bus.busy, 0);

    // Reset while waiting on the core, then a stale core result
    @(negedge clk); core_delay = 50; bus.req_valid = 4'b0001;
    @(negedge clk); bus.req_valid = '0;
    for (int c = 0; c < 20 && !bus.inv_dout_ready; c++) begin @(negedge clk); #2; end
    repeat (3) @(negedge clk);
    @(negedge clk); rst = 1'b1; #2;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_dout_ready", bus.inv_dout_ready, 0);
    @(negedge clk); rst = 1'b0; force_dv = 1'b1; force_res = 16'd9;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      chk("stale_dout_ready", bus.inv_dout_ready, 0);
      chk("stale_busy", bus.busy, 0);
      chk("stale_rsp_valid", bus.rsp_valid, 0);
    end
    chk("midrst_rsp_res", bus.rsp_res, 0);
    chk("midrst_last_latency", bus.last_latency, 0);
    @(negedge clk); force_dv = 1'b0;

    // Latency saturation: 70000-cycle core stall
    @(negedge clk); core_delay = 70000; bus.req_valid = 4'b0100;
    exp_q.push_back('{2, 16'd7, 16'd65535});
    #2 chk("sat_req_ready", bus.req_ready, 4'b0100);
    @(negedge clk); bus.req_valid = '0;
    wait_done(80000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modinv_arbiter.md
MODINV_ARBITER -- requirements
Module: modinv_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1024: operand and result width.
REQ-002 SHALL have parameter NUM_REQ, default 4: requester count, range 2..16; IW = clog2(NUM_REQ).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester job request.
REQ-007 req_ready  out  NUM_REQ  per-requester accept.
REQ-008 req_base  in  NUM_REQ*DATA_WIDTH  base operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_mod  in  NUM_REQ*DATA_WIDTH  modulus operands; same slicing as req_base.
REQ-010 rsp_valid  out  NUM_REQ  per-requester result valid.
REQ-011 rsp_ready  in  NUM_REQ  per-requester result accept.
REQ-012 rsp_res  out  DATA_WIDTH  shared result bus.
REQ-013 inv_din_valid  out  1, inv_din_ready  in  1, inv_din_base  out  DATA_WIDTH, inv_din_mod  out  DATA_WIDTH: modular-inverse core input channel.
REQ-014 inv_dout_valid  in  1, inv_dout_ready  out  1, inv_dout_res  in  DATA_WIDTH: core output channel.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 owner  out  IW  index of the requester currently being served.
REQ-017 last_latency  out  16  core cycles used by the last completed job.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_RES, RETURN, serving exactly one job at a time.
REQ-019 IDLE: SHALL select winner g round-robin among asserted req_valid bits, searching from last_grant+1 modulo NUM_REQ.
REQ-019a IDLE: SHALL drive req_ready[g]=1 combinationally and all other req_ready bits 0.
REQ-019b IDLE: on transfer SHALL latch base, mod and owner=g, then go to ISSUE.
REQ-019c IDLE: SHALL remain in IDLE with all req_ready bits 0 when req_valid is all zero.
REQ-020 req_ready SHALL be 0 in every state except IDLE; at most one req_ready bit SHALL be high in any cycle.
REQ-021 ISSUE: inv_din_valid=1 with latched operands held stable; on inv_din_ready go to WAIT_RES and clear the latency counter.
REQ-022 WAIT_RES: inv_dout_ready=1; latency counter +1 per cycle, saturating at 65535; on inv_dout_valid latch inv_dout_res and the counter into last_latency, then go to RETURN.
REQ-023 inv_dout_ready SHALL be 0 outside WAIT_RES; inv_dout_valid outside WAIT_RES SHALL be ignored.
REQ-024 RETURN: rsp_valid[owner]=1 only; rsp_res = latched result; on rsp_ready[owner] set last_grant=owner and go to IDLE.
REQ-024a RETURN: rsp_ready bits of non-owners SHALL be ignored.
REQ-025 rsp_res SHALL hold the last latched result outside RETURN.
REQ-026 Minimum latency SHALL be: accept at cycle t, inv_din_valid at t+1; result latched at cycle r, rsp_valid at r+1.
REQ-027 A requester dropping req_valid before being granted SHALL lose no state and SHALL cause no transfer.
REQ-028 A requester holding req_valid while another is served SHALL keep its place; every continuously asserted requester SHALL be granted within NUM_REQ jobs.
REQ-029 After a job completes, a new request SHALL be grantable in the same cycle the FSM re-enters IDLE; there SHALL be no dead cycle beyond the IDLE cycle.

Reset
REQ-030 On rst: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), owner=0, last_latency=0, latched operands and result=0, latency counter=0.
REQ-031 During rst, all valid/ready outputs and busy SHALL be 0.
REQ-032 rst mid-job SHALL abort the job with no response; a core result arriving after reset SHALL be ignored because inv_dout_ready=0 in IDLE.

Verification
REQ-033 Single job: req_valid=0001, base=3, mod=7, core returns 5 after 10 cycles -> rsp_valid=0001, rsp_res=5, last_latency=10, busy falls on the handshake.
REQ-034 Contention: req_valid=1111 held from reset, each job returns at once -> grant order 0,1,2,3,0; req_ready never has more than one bit set.
REQ-035 Backpressure: inv_din_ready low for 5 cycles, rsp_ready[owner] low for 3 cycles -> inv_din_* and rsp_res stable; a non-owner rsp_ready=1 produces no completion.
REQ-036 Reset mid-WAIT_RES, then core asserts inv_dout_valid with 9 -> no rsp_valid, state IDLE, inv_dout_ready=0.
REQ-037 Latency saturation: core stalls 70000 cycles -> last_latency=65535.
REQ-038 Withdraw: req_valid[2] pulsed while requester 1 is served -> no grant or transfer to requester 2.
